// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares the single L2 request port between NUM_CORES L1s.
//
// One pending L1 request is selected at a time. EVICT requests take
// priority over all other types. Within each class the scan starts at
// rr_ptr and wraps around. The granted packet is held on the L2 input
// until the L2 reports completion. A watchdog abandons a transaction that
// the L2 never completes and raises a sticky error flag.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   req_valid/packet    per-core request, held by the L1 until req_ready
//   req_ready           one-hot accept pulse, combinational, IDLE only
//   l2_req_valid        l2_entry_packet carries a live transaction
//   l2_entry_packet     granted request (core_id forced), zero when idle
//   l2_stall, l2_done   L2 back-pressure and completion pulse
//   grant_core          core id of the current or most recent grant
//   busy, timeout_err   FSM not idle; sticky watchdog flag
//   dbg_state_o         FSM state: 0 = IDLE, 1 = ISSUE, 2 = WAIT
//   dbg_rr_ptr_o        round-robin scan start pointer
//
// Handshakes:
//   L1 side: a request transfers in the cycle where req_valid[c] and
//     req_ready[c] are both high. The L1 keeps req_valid[c] and
//     req_packet[c] stable until then.
//   L2 side: the presented packet is accepted on a cycle with
//     l2_req_valid=1 and l2_stall=0. Completion is the l2_done pulse in
//     that cycle or in any later cycle.

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package l2_pkg;
  localparam int CORE_ID_W = 4;
  typedef logic [CORE_ID_W-1:0] core_id_t;
  typedef enum logic [1:0] {
    REQ_READ  = 2'd0,
    REQ_WRITE = 2'd1,
    REQ_EVICT = 2'd2
  } req_type_e;
  typedef struct packed {
    req_type_e   req_type;
    core_id_t    core_id;
    logic [15:0] addr;
    logic [31:0] data;
  } l2_entry_packet_t;
endpackage

module l2_req_arbiter
  import l2_pkg::*;
#(
  parameter int NUM_CORES = `NUM_CORES,
  parameter int TIMEOUT   = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             req_valid,
  input  l2_entry_packet_t [NUM_CORES-1:0] req_packet,
  output logic [NUM_CORES-1:0]             req_ready,
  output logic                             l2_req_valid,
  output l2_entry_packet_t                 l2_entry_packet,
  input  logic                             l2_stall,
  input  logic                             l2_done,
  output logic [$clog2(NUM_CORES)-1:0]     grant_core,
  output logic                             busy,
  output logic                             timeout_err,
  output logic [1:0]                       dbg_state_o,
  output logic [$clog2(NUM_CORES)-1:0]     dbg_rr_ptr_o
);
  localparam int CW  = $clog2(NUM_CORES);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [CW-1:0]  LAST_CORE = CW'(NUM_CORES - 1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX    = {WDW{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
  l2_entry_packet_t pkt_q, pkt_d;
  logic [CW-1:0]    grant_q, grant_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Rotating scan starting at rr_ptr. Both classes are found in one pass:
  // the first EVICT seen and the first valid request of any type.
  logic          ev_found, any_found;
  logic [CW-1:0] ev_idx, any_idx, scan_idx, win_idx;

  always_comb begin
    ev_found  = 1'b0;
    any_found = 1'b0;
    ev_idx    = '0;
    any_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      // Explicit wrap so that non-power-of-two core counts work.
      if (int'(rr_ptr_q) + i >= NUM_CORES) scan_idx = CW'(int'(rr_ptr_q) + i - NUM_CORES);
      else                                  scan_idx = CW'(int'(rr_ptr_q) + i);
      if (req_valid[scan_idx]) begin
        if (!any_found) begin
          any_found = 1'b1;
          any_idx   = scan_idx;
        end
        if (!ev_found && req_packet[scan_idx].req_type == REQ_EVICT) begin
          ev_found = 1'b1;
          ev_idx   = scan_idx;
        end
      end
    end
    win_idx = ev_found ? ev_idx : any_idx;
  end

  // The pointer moves past the core that was just served.
  logic [CW-1:0] next_ptr;
  assign next_ptr = (grant_q == LAST_CORE) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    pkt_d         = pkt_q;
    grant_d       = grant_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    req_ready     = '0;
    case (state_q)
      S_IDLE: begin
        // The reset term keeps req_ready low while reset is held.
        if (any_found && reset) begin
          req_ready[win_idx] = 1'b1;
          pkt_d              = req_packet[win_idx];
          pkt_d.core_id      = core_id_t'(win_idx);
          grant_d            = win_idx;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // l2_done during a stall is ignored: nothing has been accepted yet.
        if (!l2_stall) begin
          if (l2_done) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            state_d  = S_WAIT;
            wd_cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
        if (l2_done) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
          rr_ptr_d      = next_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      pkt_q         <= '0;
      grant_q       <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      pkt_q         <= pkt_d;
      grant_q       <= grant_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign l2_req_valid    = busy;
  assign l2_entry_packet = busy ? pkt_q : '0;
  assign grant_core      = grant_q;
  assign timeout_err     = timeout_err_q;
  assign dbg_state_o     = state_q;
  assign dbg_rr_ptr_o    = rr_ptr_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Testbench for l2_req_arbiter: directed scenarios followed by randomized
// traffic. The reference model tracks the pending request of each L1, the
// round-robin pointer and the sticky error flag, and predicts every grant.
`timescale 1ns/1ps

module tb_l2_req_arbiter;
  import l2_pkg::*;

  localparam int N = 4;
  localparam int T = 8;

  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [N-1:0]             req_valid;
  l2_entry_packet_t [N-1:0] req_packet;
  logic [N-1:0]             req_ready;
  logic                     l2_req_valid;
  l2_entry_packet_t         l2_entry_packet;
  logic                     l2_stall;
  logic                     l2_done;
  logic [1:0]               grant_core;
  logic                     busy;
  logic                     timeout_err;
  logic [1:0]               dbg_state;
  logic [1:0]               dbg_rr_ptr;

  l2_req_arbiter #(.NUM_CORES(N), .TIMEOUT(T)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_packet      (req_packet),
    .req_ready       (req_ready),
    .l2_req_valid    (l2_req_valid),
    .l2_entry_packet (l2_entry_packet),
    .l2_stall        (l2_stall),
    .l2_done         (l2_done),
    .grant_core      (grant_core),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .dbg_state_o     (dbg_state),
    .dbg_rr_ptr_o    (dbg_rr_ptr)
  );

  // ---------------- scoreboard / model ----------------
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [63:0]      exp_q[$];
  bit               pend_v[N];
  l2_entry_packet_t pend_pkt[N];
  int               m_rr   = 0;
  bit               m_terr = 1'b0;
  int               rr_order[5] = '{0, 1, 2, 3, 0};
  int               ev_order[3] = '{3, 0, 1};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Rotating scan from the model pointer: EVICT class first, then any.
  function automatic int exp_winner();
    for (int k = 0; k < N; k++) begin
      int c = (m_rr + k) % N;
      if (pend_v[c] && pend_pkt[c].req_type == REQ_EVICT) return c;
    end
    for (int k = 0; k < N; k++) begin
      int c = (m_rr + k) % N;
      if (pend_v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_req(input int c, input req_type_e t);
    pend_v[c]            = 1'b1;
    pend_pkt[c].req_type = t;
    pend_pkt[c].core_id  = core_id_t'($urandom_range(0, 15));
    pend_pkt[c].addr     = 16'($urandom);
    pend_pkt[c].data     = $urandom;
  endtask

  // Idle lanes carry random junk, including EVICT types, which must be ignored.
  task automatic drive_reqs();
    for (int c = 0; c < N; c++) begin
      req_valid[c] = pend_v[c];
      if (pend_v[c]) begin
        req_packet[c] = pend_pkt[c];
      end else begin
        req_packet[c].req_type = req_type_e'($urandom_range(0, 2));
        req_packet[c].core_id  = core_id_t'($urandom_range(0, 15));
        req_packet[c].addr     = 16'($urandom);
        req_packet[c].data     = $urandom;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset    = 1'b0;
    l2_stall = 1'b0;
    l2_done  = 1'b0;
    req_valid = '1;
    for (int c = 0; c < N; c++) pend_v[c] = 1'b0;
    m_rr   = 0;
    m_terr = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_l2_valid", 64'(l2_req_valid), 64'(0));
    chk("rst_packet", 64'(l2_entry_packet), 64'(0));
    chk("rst_grant_core", 64'(grant_core), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    chk("rst_rr_ptr", 64'(dbg_rr_ptr), 64'(0));
    reset = 1'b1;
    drive_reqs();
  endtask

  // Called at a negedge with the DUT in IDLE. n_wait < 0: done in the
  // accepting ISSUE cycle; 0..T-1: done on that WAIT cycle; >= T: no done.
  task automatic run_txn(input int n_stall, input int n_wait,
                         output int winner, output int grant_cyc);
    int               w;
    l2_entry_packet_t exp_p;
    logic [63:0]      exp_raw;
    drive_reqs();
    #1;
    w         = exp_winner();
    winner    = w;
    grant_cyc = cyc;
    chk("req_ready", 64'(req_ready), (w < 0) ? 64'(0) : 64'(1) << w);
    if (w < 0) begin
      // l2_done while idle must be ignored.
      l2_done = 1'($urandom_range(0, 1));
      @(negedge clock);
      l2_done = 1'b0;
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_terr", 64'(timeout_err), 64'(m_terr));
      return;
    end
    exp_p         = pend_pkt[w];
    exp_p.core_id = core_id_t'(w);
    exp_q.push_back(64'(exp_p));
    pend_v[w] = 1'b0;

    @(negedge clock);
    drive_reqs();
    exp_raw = exp_q.pop_front();
    chk("issue_valid", 64'(l2_req_valid), 64'(1));
    chk("issue_grant", 64'(grant_core), 64'(w));
    chk("issue_packet", 64'(l2_entry_packet), exp_raw);
    chk("issue_busy", 64'(busy), 64'(1));

    for (int s = 0; s < n_stall; s++) begin
      l2_stall = 1'b1;
      l2_done  = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("stall_state", 64'(dbg_state), 64'(ST_ISSUE));
      chk("stall_packet", 64'(l2_entry_packet), exp_raw);
      chk("stall_ready", 64'(req_ready), 64'(0));
    end
    l2_stall = 1'b0;
    l2_done  = (n_wait < 0);
    @(negedge clock);
    l2_done  = 1'b0;
    if (n_wait >= 0) begin
      for (int j = 0; j < T; j++) begin
        chk("wait_state", 64'(dbg_state), 64'(ST_WAIT));
        chk("wait_packet", 64'(l2_entry_packet), exp_raw);
        chk("wait_grant", 64'(grant_core), 64'(w));
        l2_stall = 1'($urandom_range(0, 1));
        l2_done  = (j == n_wait);
        @(negedge clock);
        l2_stall = 1'b0;
        l2_done  = 1'b0;
        if (j == n_wait) break;
      end
    end
    m_rr = (w + 1) % N;
    if (n_wait >= T) m_terr = 1'b1;
    chk("end_busy", 64'(busy), 64'(0));
    chk("end_l2_valid", 64'(l2_req_valid), 64'(0));
    chk("end_packet", 64'(l2_entry_packet), 64'(0));
    chk("end_rr_ptr", 64'(dbg_rr_ptr), 64'(m_rr));
    chk("end_terr", 64'(timeout_err), 64'(m_terr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w, gc, prev_gc, mode;
    req_valid  = '0;
    req_packet = '0;
    l2_stall   = 1'b0;
    l2_done    = 1'b0;

    // Reset values, then a single READ from core 2.
    reset_dut();
    new_req(2, REQ_READ);
    run_txn(0, 1, w, gc);
    chk("single_winner", 64'(w), 64'(2));
    chk("single_rr_ptr", 64'(dbg_rr_ptr), 64'(3));

    // Round-robin among four continuous READs, completed in ISSUE.
    reset_dut();
    for (int c = 0; c < N; c++) new_req(c, REQ_READ);
    prev_gc = 0;
    for (int k = 0; k < 5; k++) begin
      run_txn(0, -1, w, gc);
      chk("rr_order", 64'(w), 64'(rr_order[k]));
      if (k > 0) chk("rr_gap", 64'(gc - prev_gc), 64'(2));
      prev_gc = gc;
      if (w >= 0) new_req(w, REQ_READ);
    end

    // EVICT priority.
    reset_dut();
    new_req(0, REQ_READ);
    new_req(1, REQ_READ);
    new_req(3, REQ_EVICT);
    for (int k = 0; k < 3; k++) begin
      run_txn(0, 0, w, gc);
      chk("evict_order", 64'(w), 64'(ev_order[k]));
    end

    // Stall hold for five ISSUE cycles with stray l2_done pulses.
    new_req(1, REQ_WRITE);
    run_txn(5, -1, w, gc);
    chk("stall_winner", 64'(w), 64'(1));

    // Watchdog, then a further request must still be served.
    new_req(0, REQ_READ);
    run_txn(0, T, w, gc);
    chk("wd_terr", 64'(timeout_err), 64'(1));
    new_req(3, REQ_READ);
    run_txn(0, 2, w, gc);
    chk("wd_next_winner", 64'(w), 64'(3));

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      for (int c = 0; c < N; c++)
        if (!pend_v[c] && $urandom_range(0, 2) == 0)
          new_req(c, req_type_e'($urandom_range(0, 2)));
      mode = int'($urandom_range(0, 9));
      run_txn(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
              (mode == 0) ? T : (mode < 4) ? -1 : int'($urandom_range(0, T - 1)),
              w, gc);
    end

    // Asynchronous reset in WAIT, request held high throughout.
    @(negedge clock);
    for (int c = 0; c < N; c++) pend_v[c] = 1'b0;
    new_req(1, REQ_READ);
    drive_reqs();
    @(negedge clock);
    drive_reqs();
    @(negedge clock);
    @(negedge clock);
    chk("arst_pre_state", 64'(dbg_state), 64'(ST_WAIT));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_l2_valid", 64'(l2_req_valid), 64'(0));
    chk("arst_packet", 64'(l2_entry_packet), 64'(0));
    chk("arst_grant", 64'(grant_core), 64'(0));
    chk("arst_terr", 64'(timeout_err), 64'(0));
    chk("arst_ready", 64'(req_ready), 64'(0));
    chk("arst_rr_ptr", 64'(dbg_rr_ptr), 64'(0));
    @(negedge clock);
    reset  = 1'b1;
    m_rr   = 0;
    m_terr = 1'b0;
    run_txn(0, 0, w, gc);
    chk("arst_regrant", 64'(w), 64'(1));

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_req_arbiter.md
# l2_req_arbiter

Shares the single L2Cache request port between `NUM_CORES` L1 caches. Selects one pending L1 request at a time, with EVICT requests taking priority and round-robin ordering within each class. Holds the granted `L2_ENTRY_PACKET` stable on the L2 input until the L2 reports completion. A watchdog flags transactions that the L2 never completes.

## Interface

Parameters:
- `NUM_CORES`, default `` `NUM_CORES `` (4): number of requesting L1s; any value ≥2, power of two not required.
- `TIMEOUT`, default 1024: maximum cycles in WAIT before the watchdog fires; ≥1.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_CORES  per-core request pending; L1 holds it and `req_packet[c]` stable until `req_ready[c]`.
- `req_packet`  in  NUM_CORES × $bits(L2_ENTRY_PACKET)  per-core request.
- `req_ready`  out  NUM_CORES  one-hot, single-cycle accept pulse.
- `l2_req_valid`  out  1  `l2_entry_packet` holds a live transaction.
- `l2_entry_packet`  out  $bits(L2_ENTRY_PACKET)  granted request; all-zero when `l2_req_valid`=0.
- `l2_stall`  in  1  L2 cannot accept the presented request this cycle.
- `l2_done`  in  1  single-cycle pulse: L2 finished the current transaction.
- `grant_core`  out  $clog2(NUM_CORES)  core id of the current transaction.
- `busy`  out  1  state ≠ IDLE.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- Registers: `state`, `rr_ptr`, `pkt_q`, `grant_q`, `wd_cnt`, `timeout_err`.

Arbitration, evaluated combinationally in IDLE only:
- Evict class: cores with `req_valid[c]`=1 and `req_packet[c].req_type`=EVICT.
- If the evict class is non-empty, the winner is its first member scanning c = rr_ptr, rr_ptr+1, …, wrapping at NUM_CORES-1→0.
- Otherwise the winner is the first core with `req_valid` set, using the same scan.
- On a winner:
  - `req_ready[winner]`=1 that cycle.
  - `pkt_q`←`req_packet[winner]`, with `core_id` forced to the winner.
  - `grant_q`←winner.
  - state→ISSUE.

State behaviour:
- IDLE with no `req_valid`: stay in IDLE; `req_ready`=0.
- ISSUE:
  - `l2_req_valid`=1 and `l2_entry_packet`=`pkt_q`.
  - `l2_stall`=1: stay in ISSUE.
  - `l2_stall`=0 and `l2_done`=0: go to WAIT; `wd_cnt`←0.
  - `l2_stall`=0 and `l2_done`=1: go to IDLE (accept and complete in the same cycle).
- WAIT:
  - Same outputs as ISSUE; `wd_cnt` increments each cycle.
  - `l2_done`=1: go to IDLE.
  - `wd_cnt`=TIMEOUT-1 without `l2_done`: set `timeout_err`=1, go to IDLE.
  - `l2_stall` is ignored.
- Every transition out of ISSUE or WAIT into IDLE, including the timeout exit, updates `rr_ptr`←(`grant_q`+1) mod NUM_CORES.
  - Explicit compare-and-wrap; no reliance on power-of-two overflow.
- `l2_done` in IDLE is ignored; no state change, no error.
- `l2_done` with `l2_stall`=1 in ISSUE is ignored; the request has not yet been accepted.
- `timeout_err` clears only on reset.
- Widths:
  - `rr_ptr` and `grant_q` are $clog2(NUM_CORES) bits.
  - `wd_cnt` is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

## Timing

- Reset (async assert, sync release) drives:
  - state=IDLE, `rr_ptr`=0, `pkt_q`=0, `grant_q`=0, `wd_cnt`=0.
  - All outputs 0: `req_ready`, `l2_req_valid`, `l2_entry_packet`, `grant_core`, `busy`, `timeout_err`.
- Reset mid-transaction abandons it. No `req_ready` is re-issued; the L1 must re-present its request.
- Latency:
  - `req_valid` sampled in IDLE at cycle t gives `req_ready` at t and `l2_req_valid` at t+1.
  - Minimum transaction is 2 cycles: ISSUE with `l2_done`, then one IDLE arbitration cycle.
  - Back-to-back grants are separated by exactly one IDLE cycle.
- `req_ready` is combinational from `req_valid` and registered state; no other output is combinational.
- `l2_entry_packet` and `grant_core` are stable for the whole ISSUE+WAIT interval.
- Starvation bound: a continuously asserted non-EVICT request is granted after at most NUM_CORES-1 non-EVICT grants, absent EVICT traffic.

## Test plan

- Single request: core 2 READ at t0 from reset -> `req_ready`=4'b0100 at t0; `l2_req_valid`=1 with `grant_core`=2 at t0+1; with `l2_stall`=0, `l2_done` at t0+3 -> `busy`=0 at t0+4, `rr_ptr`=3.
- Round-robin: all 4 cores assert READ continuously, `l2_done` on every ISSUE cycle -> grant order 0,1,2,3,0; grants every 2 cycles.
- Evict priority: cores 0,1 READ and core 3 EVICT, `rr_ptr`=0 -> core 3 granted first, then 0, then 1.
- Stall hold: `l2_stall`=1 for 5 ISSUE cycles -> `l2_entry_packet` unchanged, state stays ISSUE; `l2_done` asserted during the stall -> ignored.
- Watchdog: TIMEOUT=8, never assert `l2_done` -> `timeout_err`=1 after 8 WAIT cycles, return to IDLE, `rr_ptr` advanced; next request still granted.
- Async reset asserted in WAIT -> all outputs 0 immediately, with no clock edge required.
